// File: rtl/trdb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trdb_pkg
// Purpose  : Shared definitions for the trace debug stream merger:
//            timestamp width, packet header fields and the merger FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package trdb_pkg;

    localparam int unsigned TIMESTAMP_WIDTH = 64;

    // Header word layout: length in [3:0], packet type in [5:4].
    localparam logic [1:0] PKT_TYPE_SW    = 2'b10;
    localparam logic [1:0] PKT_TYPE_TIMER = 2'b11;

    // Length field counts the payload words following the header.
    localparam logic [3:0] SW_PKT_LEN     = 4'd1;
    localparam logic [3:0] TIMER_PKT_LEN  = 4'd2;

    localparam logic [31:0] SW_HEADER     = {26'b0, PKT_TYPE_SW, SW_PKT_LEN};       // 0x21
    localparam logic [31:0] TIMER_HEADER  = {26'b0, PKT_TYPE_TIMER, TIMER_PKT_LEN}; // 0x32

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRACE    = 3'd1,
        TIME_HDR = 3'd2,
        TIME_LO  = 3'd3,
        TIME_HI  = 3'd4,
        SW_HDR   = 3'd5,
        SW_DATA  = 3'd6
    } merger_state_e;

endpackage
`default_nettype wire

// File: rtl/trdb_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : trdb_stream_merger
// Purpose  : Merges framed trace packets, timestamp packets and software dump
//            words into a single valid/ready word stream. Trace packets are
//            never interleaved. Also handles flush confirmation.
// Ports    : clk_i, rst_ni (async, active-low), enable_i
//            trace_data_i/trace_last_i/trace_valid_i -> trace_grant_o
//            sw_word_i/sw_valid_i -> sw_grant_o
//            tu_req_i -> timer_drop_o (request discarded)
//            flush_stream_i -> flush_confirm_o
//            data_o/valid_o/ready_i : merged output stream
// Revision : 1.0 - initial release
// ============================================================================
module trdb_stream_merger
    import trdb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [31:0] trace_data_i,
    input  logic        trace_last_i,
    input  logic        trace_valid_i,
    output logic        trace_grant_o,
    input  logic [31:0] sw_word_i,
    input  logic        sw_valid_i,
    output logic        sw_grant_o,
    input  logic        tu_req_i,
    input  logic        flush_stream_i,
    output logic        flush_confirm_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        timer_drop_o
);

    merger_state_e               r_state;
    logic [TIMESTAMP_WIDTH-1:0]  r_ts;
    logic [TIMESTAMP_WIDTH-1:0]  r_ts_cap;
    logic                        r_timer_pending;
    logic                        r_flush_arm;
    logic                        r_flush_confirm;

    logic                        w_accept;
    logic                        w_flush_ok;

    // Output word decode. Header and timestamp words come from registers, so
    // they are stable during a stall; trace and software words are held by
    // their sources until granted.
    always_comb begin
        data_o        = '0;
        valid_o       = 1'b0;
        trace_grant_o = 1'b0;
        sw_grant_o    = 1'b0;
        case (r_state)
            TRACE: begin
                data_o        = trace_data_i;
                valid_o       = trace_valid_i;
                trace_grant_o = trace_valid_i & ready_i;
            end
            TIME_HDR: begin
                data_o  = TIMER_HEADER;
                valid_o = 1'b1;
            end
            TIME_LO: begin
                data_o  = r_ts_cap[31:0];
                valid_o = 1'b1;
            end
            TIME_HI: begin
                data_o  = r_ts_cap[63:32];
                valid_o = 1'b1;
            end
            SW_HDR: begin
                data_o  = SW_HEADER;
                valid_o = 1'b1;
            end
            SW_DATA: begin
                data_o     = sw_word_i;
                valid_o    = sw_valid_i;
                sw_grant_o = sw_valid_i & ready_i;
            end
            default: ;
        endcase
    end

    assign w_accept     = valid_o & ready_i;

    // A request while a timestamp is still pending (including while that
    // packet is on the wire) is discarded in the same cycle.
    assign timer_drop_o = tu_req_i & r_timer_pending;

    assign w_flush_ok   = flush_stream_i & r_flush_arm & (r_state == IDLE) &
                          ~trace_valid_i & ~r_timer_pending & ~sw_valid_i;

    assign flush_confirm_o = r_flush_confirm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= IDLE;
            r_ts            <= '0;
            r_ts_cap        <= '0;
            r_timer_pending <= 1'b0;
            r_flush_arm     <= 1'b1;
            r_flush_confirm <= 1'b0;
        end else begin
            if (enable_i) begin
                r_ts <= r_ts + TIMESTAMP_WIDTH'(1);
            end

            // Capture takes priority; a clear can only happen while pending,
            // in which case a simultaneous request is the dropped one.
            if (tu_req_i && !r_timer_pending) begin
                r_ts_cap        <= r_ts;
                r_timer_pending <= 1'b1;
            end else if (r_state == TIME_HI && w_accept) begin
                r_timer_pending <= 1'b0;
            end

            // Re-arm only after the flush request has been seen low.
            r_flush_confirm <= w_flush_ok;
            if (!flush_stream_i) begin
                r_flush_arm <= 1'b1;
            end else if (w_flush_ok) begin
                r_flush_arm <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        if (trace_valid_i) begin
                            r_state <= TRACE;
                        end else if (r_timer_pending) begin
                            r_state <= TIME_HDR;
                        end else if (sw_valid_i) begin
                            r_state <= SW_HDR;
                        end
                    end
                end
                TRACE: begin
                    if (w_accept && trace_last_i) begin
                        r_state <= IDLE;
                    end
                end
                TIME_HDR: if (w_accept) r_state <= TIME_LO;
                TIME_LO:  if (w_accept) r_state <= TIME_HI;
                TIME_HI:  if (w_accept) r_state <= IDLE;
                SW_HDR:   if (w_accept) r_state <= SW_DATA;
                SW_DATA:  if (w_accept) r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trdb_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_trdb_stream_merger
// Purpose  : Self-checking bench for trdb_stream_merger. A packet-level
//            reference model parses every accepted output word and checks it
//            against the trace/software/timestamp traffic the bench generated.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trdb_stream_merger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] trace_data = '0;
    logic        trace_last = 1'b0;
    logic        trace_valid = 1'b0;
    logic        trace_grant;
    logic [31:0] sw_word = '0;
    logic        sw_valid = 1'b0;
    logic        sw_grant;
    logic        tu_req = 1'b0;
    logic        flush = 1'b0;
    logic        flush_confirm;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready = 1'b0;
    logic        timer_drop;

    trdb_stream_merger dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .trace_data_i   (trace_data),
        .trace_last_i   (trace_last),
        .trace_valid_i  (trace_valid),
        .trace_grant_o  (trace_grant),
        .sw_word_i      (sw_word),
        .sw_valid_i     (sw_valid),
        .sw_grant_o     (sw_grant),
        .tu_req_i       (tu_req),
        .flush_stream_i (flush),
        .flush_confirm_o(flush_confirm),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready),
        .timer_drop_o   (timer_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Sources (what is driven) and expectations (what the model predicts).
    logic [32:0] tr_q[$];
    logic [32:0] exp_tr_q[$];
    logic [31:0] sw_q[$];
    logic [31:0] exp_sw_q[$];
    logic [63:0] exp_tm_q[$];
    logic [31:0] got_q[$];
    int          acc_cyc[$];

    logic [63:0] m_ts;
    bit          m_pending;
    int          p_mode;
    bit          stall_prev;
    logic [31:0] stall_data;
    logic [31:0] s_data;
    logic        s_valid;
    int          drops, confirms, tgr, cyc_n;

    localparam int P_BOUND = 0, P_TRACE = 1, P_TLO = 2, P_THI = 3, P_SW = 4;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        trace_valid = (tr_q.size() > 0);
        {trace_last, trace_data} = (tr_q.size() > 0) ? tr_q[0] : 33'h0;
        sw_valid = (sw_q.size() > 0);
        sw_word  = (sw_q.size() > 0) ? sw_q[0] : 32'h0;
    endtask

    task automatic parse_word();
        logic [32:0] e;
        logic [63:0] t;
        case (p_mode)
            P_BOUND, P_TRACE: begin
                if (trace_grant || p_mode == P_TRACE) begin
                    chk("trace_grant", trace_grant, 1);
                    chk("trace_avail", exp_tr_q.size() > 0, 1);
                    if (exp_tr_q.size() > 0) begin
                        e = exp_tr_q.pop_front();
                        chk("trace_word", data_o, e[31:0]);
                        p_mode = e[32] ? P_BOUND : P_TRACE;
                    end
                end else if (data_o == 32'h32) begin
                    chk("timer_hdr_expected", exp_tm_q.size() > 0, 1);
                    p_mode = P_TLO;
                end else begin
                    chk("sw_header", data_o, 32'h21);
                    chk("sw_hdr_expected", exp_sw_q.size() > 0, 1);
                    p_mode = P_SW;
                end
            end
            P_TLO: begin
                t = (exp_tm_q.size() > 0) ? exp_tm_q[0] : 64'h0;
                chk("ts_lo", data_o, t[31:0]);
                p_mode = P_THI;
            end
            P_THI: begin
                t = (exp_tm_q.size() > 0) ? exp_tm_q.pop_front() : 64'h0;
                chk("ts_hi", data_o, t[63:32]);
                m_pending = 1'b0;
                p_mode = P_BOUND;
            end
            default: begin
                chk("sw_word", data_o, (exp_sw_q.size() > 0) ? exp_sw_q.pop_front() : 32'h0);
                p_mode = P_BOUND;
            end
        endcase
    endtask

    // One clock cycle: present sources, sample on the falling edge, update
    // the model, then step past the rising edge.
    task automatic cyc();
        drive_src();
        @(negedge clk);
        s_valid = valid_o;
        s_data  = data_o;
        if (stall_prev) begin
            chk("hold_valid", valid_o, 1);
            chk("hold_data", data_o, stall_data);
        end
        stall_prev = valid_o && !ready;
        stall_data = data_o;
        chk("timer_drop", timer_drop, tu_req && m_pending);
        if (tu_req && !m_pending) begin
            exp_tm_q.push_back(m_ts);
            m_pending = 1'b1;
        end
        if (timer_drop) drops++;
        if (flush_confirm) confirms++;
        if (valid_o && ready) begin
            got_q.push_back(data_o);
            acc_cyc.push_back(cyc_n);
            parse_word();
        end
        if (trace_grant) begin
            tgr++;
            if (tr_q.size() > 0) void'(tr_q.pop_front());
        end
        if (sw_grant && sw_q.size() > 0) void'(sw_q.pop_front());
        if (enable) m_ts++;
        cyc_n++;
        @(posedge clk);
        #1;
        tu_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 0; ready = 0; tu_req = 0; flush = 0;
        tr_q.delete(); exp_tr_q.delete(); sw_q.delete(); exp_sw_q.delete();
        exp_tm_q.delete(); got_q.delete(); acc_cyc.delete();
        drive_src();
        m_ts = 0; m_pending = 0; p_mode = P_BOUND; stall_prev = 0;
        drops = 0; confirms = 0; tgr = 0; cyc_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_words(input string nm, input logic [31:0] e[$]);
        chk({nm, "_count"}, got_q.size(), e.size());
        foreach (e[i]) begin
            chk(nm, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, e[i]);
        end
    endtask

    task automatic push_trace(input logic [31:0] d, input bit last);
        tr_q.push_back({last, d});
        exp_tr_q.push_back({last, d});
    endtask

    task automatic push_sw(input logic [31:0] d);
        sw_q.push_back(d);
        exp_sw_q.push_back(d);
    endtask

    typedef struct {
        bit          en;
        bit          tu;
        bit          tr;
        bit          sw;
        bit          exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] ew[$];
    logic [63:0] tv;

    initial begin
        // IDLE arbitration: inputs applied from reset, first output word checked.
        vecs[0] = '{1, 1, 1, 1, 1, 32'hA5A5_0001};
        vecs[1] = '{1, 1, 0, 1, 1, 32'h0000_0032};
        vecs[2] = '{1, 0, 0, 1, 1, 32'h0000_0021};
        vecs[3] = '{0, 1, 1, 1, 0, 32'h0000_0000};
        vecs[4] = '{1, 0, 0, 0, 0, 32'h0000_0000};
        vecs[5] = '{1, 0, 1, 1, 1, 32'hA5A5_0001};

        // Reset values.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_tgrant", trace_grant, 0);
        chk("rst_sgrant", sw_grant, 0);
        chk("rst_flush", flush_confirm, 0);
        chk("rst_drop", timer_drop, 0);

        foreach (vecs[i]) begin
            do_reset();
            enable = vecs[i].en;
            tu_req = vecs[i].tu;
            cyc();
            if (vecs[i].tr) push_trace(32'hA5A5_0001, 1'b1);
            if (vecs[i].sw) push_sw(32'h5A5A_0002);
            cyc();
            cyc();
            chk("arb_valid", s_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk("arb_data", s_data, vecs[i].exp_data);
        end

        // Timestamp packet requested at counter value 10.
        do_reset();
        enable = 1; ready = 1;
        repeat (10) cyc();
        tu_req = 1;
        cyc();
        repeat (6) cyc();
        ew = '{32'h32, 32'd10, 32'd0};
        expect_words("ts10", ew);
        chk("ts10_back2back", (acc_cyc.size() == 3) ? acc_cyc[2] - acc_cyc[0] : -1, 2);

        // No interleave inside a trace packet; timer beats software afterwards.
        do_reset();
        enable = 1; ready = 1;
        push_trace(32'hA1, 0); push_trace(32'hA2, 0); push_trace(32'hA3, 1);
        for (int k = 0; k < 20 && tgr < 1; k++) cyc();
        chk("trace_first_timeout", tgr >= 1, 1);
        push_sw(32'hCAFE_F00D);
        tv = m_ts;
        tu_req = 1;
        cyc();
        repeat (15) cyc();
        ew = '{32'hA1, 32'hA2, 32'hA3, 32'h32, tv[31:0], tv[63:32], 32'h21, 32'hCAFE_F00D};
        expect_words("order", ew);

        // Stall mid timer packet, plus a second request that must be dropped.
        do_reset();
        enable = 1; ready = 0;
        repeat (2) cyc();
        tv = m_ts;
        tu_req = 1;
        cyc();
        repeat (2) cyc();
        tu_req = 1;
        cyc();
        ready = 1;
        for (int k = 0; k < 20 && got_q.size() < 1; k++) cyc();
        ready = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_data", s_data, tv[31:0]);
        end
        ready = 1;
        repeat (6) cyc();
        ew = '{32'h32, tv[31:0], tv[63:32]};
        expect_words("stall", ew);
        chk("drop_count", drops, 1);

        // Flush waits for the software packet, confirms once, re-arms on low.
        do_reset();
        enable = 1; ready = 1;
        push_sw(32'h1234_5678);
        flush = 1;
        repeat (8) cyc();
        ew = '{32'h21, 32'h1234_5678};
        expect_words("flush_sw", ew);
        chk("flush_once", confirms, 1);
        flush = 0;
        cyc();
        flush = 1;
        repeat (4) cyc();
        chk("flush_rearm", confirms, 2);
        flush = 0;

        // Reset asserted while the low timestamp word is on the output.
        do_reset();
        enable = 1; ready = 1;
        repeat (4) cyc();
        tu_req = 1;
        cyc();
        for (int k = 0; k < 20 && got_q.size() < 1; k++) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", valid_o, 0);
        do_reset();
        enable = 1; ready = 1;
        repeat (8) cyc();
        chk("no_stale", got_q.size(), 0);
        got_q.delete();
        do_reset();
        enable = 1; ready = 1;
        repeat (3) cyc();
        tu_req = 1;
        cyc();
        repeat (6) cyc();
        ew = '{32'h32, 32'd3, 32'd0};
        expect_words("restart_ts", ew);

        // Randomized traffic against the packet-level model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            ready  = ($urandom % 4) != 0;
            enable = ($urandom % 16) != 0;
            tu_req = ($urandom % 20) == 0;
            if (tr_q.size() == 0 && ($urandom % 10) == 0) begin
                int n;
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) push_trace($urandom, j == n - 1);
            end
            if (sw_q.size() < 2 && ($urandom % 12) == 0) push_sw($urandom);
            cyc();
        end
        ready = 1; enable = 1; tu_req = 0;
        repeat (300) cyc();
        chk("rand_trace_left", exp_tr_q.size(), 0);
        chk("rand_sw_left", exp_sw_q.size(), 0);
        chk("rand_tm_left", exp_tm_q.size(), 0);
        chk("rand_parser_idle", p_mode, P_BOUND);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/trdb_stream_merger.md
TRDB_STREAM_MERGER -- requirements
Module: trdb_stream_merger

Interface
REQ-001 SHALL have clk_i  in  1  clock; all state on rising edge.
REQ-002 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have enable_i  in  1  trace enable; low holds the timestamp counter and blocks packet starts.
REQ-004 SHALL have trace_data_i/trace_last_i/trace_valid_i  in  32/1/1  framed trace packet words; last marks final word.
REQ-005 SHALL have trace_grant_o  out  1  trace word consumed this cycle.
REQ-006 SHALL have sw_word_i/sw_valid_i  in  32/1  software dump word from the register block's software FIFO.
REQ-007 SHALL have sw_grant_o  out  1  software word consumed this cycle.
REQ-008 SHALL have tu_req_i  in  1  single-cycle timestamp-packet request.
REQ-009 SHALL have flush_stream_i  in  1  level flush request; flush_confirm_o  out  1  flush-done pulse.
REQ-010 SHALL have data_o/valid_o  out  32/1  merged word stream; ready_i  in  1  downstream accept.
REQ-011 SHALL have timer_drop_o  out  1  pulse when a tu_req_i is discarded.

Function
REQ-012 SHALL keep a 64-bit free-running counter, +1 per cycle while enable_i=1, wrapping 2^64-1 -> 0.
REQ-013 SHALL, on tu_req_i=1 with no timer packet pending, capture the counter value of that cycle and set timer_pending.
REQ-014 SHALL, on tu_req_i=1 with timer_pending already set, drop the request and pulse timer_drop_o the same cycle.
REQ-015 SHALL use FSM states IDLE, TRACE, TIME_HDR, TIME_LO, TIME_HI, SW_HDR, SW_DATA.
REQ-016 SHALL, in IDLE with enable_i=1, pick by priority trace_valid_i > timer_pending > sw_valid_i; enable_i=0 keeps IDLE with valid_o=0.
REQ-017 SHALL, in TRACE, drive data_o=trace_data_i, valid_o=trace_valid_i, trace_grant_o=ready_i; return to IDLE on accepted word with trace_last_i=1.
REQ-018 SHALL never interleave other words inside a trace packet; a packet in progress completes even if enable_i drops.
REQ-019 SHALL emit timer packet as TIME_HDR header 0x00000032, then TIME_LO captured[31:0], then TIME_HI captured[63:32]; timer_pending clears on TIME_HI accept.
REQ-020 SHALL emit software packet as SW_HDR header 0x00000021, then SW_DATA sw_word_i; sw_grant_o=1 only on SW_DATA accept.
REQ-021 SHALL advance a word only on valid_o & ready_i; data_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-022 SHALL allow a new packet start in the cycle after the last word of the previous one (IDLE one cycle, no bubble beyond it).
REQ-023 SHALL pulse flush_confirm_o one cycle when flush_stream_i=1, state IDLE, trace_valid_i=0, timer_pending=0, sw_valid_i=0.
REQ-024 SHALL not repeat flush_confirm_o until flush_stream_i has been low at least one cycle.
REQ-025 SHALL accept a tu_req_i arriving during any state, including while its own timer packet is being sent (counts as pending: dropped).

Reset
REQ-026 SHALL reset to: state IDLE, counter 0, timer_pending 0, flush arm 1; data_o 0, valid_o 0, trace_grant_o 0, sw_grant_o 0, flush_confirm_o 0, timer_drop_o 0.
REQ-027 SHALL abandon any packet in progress on reset assertion; no partial-packet completion after release.

Structure
REQ-028 SHALL place header constants (length [3:0], type [5:4]: SW=2'b10, TIMER=2'b11), FSM state enum and TIMESTAMP_WIDTH=64 in trdb_pkg.
REQ-029 SHALL be a single module; no sub-modules.

Verification
REQ-030 Reset, enable_i=1, ready_i=1, tu_req_i at counter 10 -> words 0x32, 10, 0 on consecutive cycles.
REQ-031 Trace 3-word packet in flight, sw_valid_i and tu_req_i raised after word 1 -> trace words 2,3, then timer packet, then 0x21 + sw word.
REQ-032 ready_i=0 for 5 cycles mid timer packet -> data_o stable, no drop/duplication after ready_i=1.
REQ-033 Two tu_req_i 3 cycles apart with ready_i=0 -> timer_drop_o pulses on second; single timer packet with first timestamp.
REQ-034 flush_stream_i held high with sw word pending -> sw packet sent, then exactly one flush_confirm_o pulse.
REQ-035 rst_ni asserted during TIME_LO -> valid_o=0 immediately; after release counter restarts at 0, no stale words.
